// File: rtl/imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into 32-bit instruction-memory writes.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
module imem_loader #(
    parameter int          ADDR_W   = 5,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [23:0]       r_word;
    logic [1:0]        r_byteIdx;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wordCnt;
    logic              r_coreReset;
    logic              r_loadDone;
    logic              r_loadErr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic w_accept;
    logic w_isHdr;
    logic w_lenBad;
    logic w_wordDone;
    logic w_lastWrite;

    assign w_accept    = rx_valid && r_ready;
    assign w_isHdr     = (rx_data == HDR_BYTE);
    assign w_lenBad    = (rx_data == 8'd0) || (32'(rx_data) > 32'(DEPTH));
    assign w_wordDone  = (r_state == DATA) && w_accept && (r_byteIdx == 2'd3);
    assign w_lastWrite = r_we && (r_wordCnt == r_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The frame only ends after the final word's write strobe has been issued.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_isHdr) w_nextState = LEN;
            end
            LEN: begin
                if (w_accept) w_nextState = w_lenBad ? ERR : DATA;
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_lastWrite) w_nextState = CSUM;
`else
                if (w_lastWrite) w_nextState = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_accept) w_nextState = (rx_data == r_csum) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (w_accept && w_isHdr) w_nextState = LEN;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Status outputs follow the state one cycle later so the core sees a clean, registered reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_word      <= '0;
            r_byteIdx   <= '0;
            r_len       <= '0;
            r_wordCnt   <= '0;
            r_coreReset <= 1'b1;
            r_loadDone  <= 1'b0;
            r_loadErr   <= 1'b0;
        end else begin
            r_ready     <= !w_wordDone;
            r_we        <= w_wordDone;
            r_coreReset <= (r_state != DONE);
            r_loadDone  <= (r_state == DONE);
            r_loadErr   <= (r_state == ERR);
            if (r_state == LEN && w_accept) begin
                r_len     <= (ADDR_W+1)'(rx_data);
                r_wordCnt <= '0;
                r_byteIdx <= '0;
            end
            if (r_state == DATA && w_accept) begin
                r_word    <= {rx_data, r_word[23:8]};
                r_byteIdx <= r_byteIdx + 2'd1;
            end
            if (w_wordDone) begin
                r_addr    <= r_wordCnt[ADDR_W-1:0];
                r_wdata   <= {rx_data, r_word};
                r_wordCnt <= r_wordCnt + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else if (r_state == LEN && w_accept) begin
            r_csum <= '0;
        end else if (r_state == DATA && w_accept) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    assign rx_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_coreReset;
    assign load_done  = r_loadDone;
    assign load_err   = r_loadErr;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random frames checked against a word-level memory model.
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum byte and its error path.
module tb_imem_loader;

    localparam int         ADDR_W = 5;
    localparam int         DEPTH  = 32;
    localparam logic [7:0] HDR    = 8'hA5;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_err;

    int checkCount = 0;
    int passCount  = 0;
    int readyViolations = 0;
    bit monitorEn = 1'b0;

    logic [31:0]       tbMem    [DEPTH];
    logic [31:0]       refMem   [DEPTH];
    bit                refValid [DEPTH];
    logic [ADDR_W-1:0] logAddr  [$];
    logic [31:0]       logData  [$];
    logic [31:0]       txWords  [$];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csumXor = 8'h00;
`endif

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .HDR_BYTE(HDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // Behaves as the instruction memory and watches the ready/write-strobe handshake.
    always @(negedge clk) begin
        if (!reset && imem_we === 1'b1) begin
            tbMem[imem_addr] = imem_wdata;
            logAddr.push_back(imem_addr);
            logData.push_back(imem_wdata);
        end
        if (monitorEn && !reset && (rx_ready === imem_we)) readyViolations++;
    end

    function automatic int memDiffs();
        int d = 0;
        for (int k = 0; k < DEPTH; k++)
            if (refValid[k] && tbMem[k] !== refMem[k]) d++;
        return d;
    endfunction

    task automatic makeWords(input int n);
        txWords.delete();
        for (int i = 0; i < n; i++) txWords.push_back($urandom);
    endtask

    // Offers one byte and returns 1 ns after the edge on which it was taken.
    task automatic sendByte(input logic [7:0] b);
        bit sent = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int n = 0; n < 20 && !sent; n++) begin
            if (rx_ready) sent = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!sent) begin
            checkCount++;
            $display("[TB] FAIL sendByte: byte %h not accepted, required acceptance within 20 cycles", b);
        end
    endtask

    task automatic sendFrame(input logic [7:0] n, input bit withHdr);
        logic [31:0] acc;
        acc = '0;
        if (n != 8'd0 && int'(n) <= DEPTH) begin
            for (int k = 0; k < txWords.size(); k++) begin
                refMem[k]   = txWords[k];
                refValid[k] = 1'b1;
            end
        end
        if (withHdr) sendByte(HDR);
        sendByte(n);
        for (int k = 0; k < txWords.size(); k++) begin
            acc ^= txWords[k];
            for (int j = 0; j < 4; j++) sendByte(txWords[k][8*j +: 8]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(acc[7:0] ^ acc[15:8] ^ acc[23:16] ^ acc[31:24] ^ csumXor);
`endif
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if ({rx_ready, imem_we, imem_addr, imem_wdata} !== '0)
            $display("[TB] FAIL reset_datapath: got ready=%b we=%b addr=%h wdata=%h, required all 0", rx_ready, imem_we, imem_addr, imem_wdata);
        else passCount++;
        checkCount++; if ({core_reset, load_done, load_err} !== 3'b100)
            $display("[TB] FAIL reset_status: got core/done/err=%b%b%b, required 100", core_reset, load_done, load_err);
        else passCount++;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        checkCount++; if (rx_ready !== 1'b1)
            $display("[TB] FAIL ready_after_reset: got %b, required 1", rx_ready);
        else passCount++;
        monitorEn = 1'b1;
    endtask

    task automatic test_garbage();
        int logStart = logAddr.size();
        int n = $urandom_range(2, 6);
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'h5A);
        makeWords(n);
        sendFrame(8'(n), 1'b1);
        settle();
        checkCount++; if (logAddr.size() - logStart !== n)
            $display("[TB] FAIL garbage_writes: got %0d writes, required %0d", logAddr.size() - logStart, n);
        else passCount++;
        checkCount++; if (memDiffs() !== 0)
            $display("[TB] FAIL garbage_mem: got %0d bad words, required 0", memDiffs());
        else passCount++;
        checkCount++; if ({core_reset, load_done} !== 2'b01)
            $display("[TB] FAIL garbage_done: got core/done=%b%b, required 01", core_reset, load_done);
        else passCount++;
        sendByte(HDR);
        @(posedge clk);
        #1;
        checkCount++; if ({core_reset, load_done} !== 2'b10)
            $display("[TB] FAIL reload_reset: got core/done=%b%b, required 10", core_reset, load_done);
        else passCount++;
        makeWords(1);
        sendFrame(8'd1, 1'b0);
        settle();
        checkCount++; if (load_done !== 1'b1 || memDiffs() !== 0)
            $display("[TB] FAIL reload_done: got done=%b bad=%0d, required done=1 bad=0", load_done, memDiffs());
        else passCount++;
    endtask

    task automatic test_single();
        refMem[0] = 32'h00000013; refValid[0] = 1'b1;
        sendByte(HDR); sendByte(8'h01);
        sendByte(8'h13); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        checkCount++; if ({imem_we, rx_ready, imem_addr, imem_wdata} !== {2'b10, 5'd0, 32'h00000013})
            $display("[TB] FAIL single_write: got we=%b ready=%b addr=%h wdata=%h, required we=1 ready=0 addr=0 wdata=00000013",
                     imem_we, rx_ready, imem_addr, imem_wdata);
        else passCount++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h13);
        checkCount++; if (core_reset !== 1'b1)
            $display("[TB] FAIL single_csum_edge: got core_reset=%b, required 1", core_reset);
        else passCount++;
        @(posedge clk);
        #1;
`else
        @(posedge clk);
        #1;
        checkCount++; if (core_reset !== 1'b1)
            $display("[TB] FAIL single_early: got core_reset=%b, required 1", core_reset);
        else passCount++;
        @(posedge clk);
        #1;
`endif
        checkCount++; if ({core_reset, load_done, load_err} !== 3'b010)
            $display("[TB] FAIL single_done: got core/done/err=%b%b%b, required 010", core_reset, load_done, load_err);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int logStart = logAddr.size();
        int violBase = readyViolations;
        txWords.delete();
        for (int k = 0; k < DEPTH; k++) txWords.push_back(32'(k));
        sendFrame(8'(DEPTH), 1'b1);
        settle();
        checkCount++; if (logAddr.size() - logStart !== DEPTH)
            $display("[TB] FAIL b2b_count: got %0d writes, required %0d", logAddr.size() - logStart, DEPTH);
        else passCount++;
        for (int k = 0; k < DEPTH && logStart + k < logAddr.size(); k++) begin
            checkCount++; if (logAddr[logStart+k] !== 5'(k) || logData[logStart+k] !== 32'(k))
                $display("[TB] FAIL b2b_word%0d: got addr=%h data=%h, required addr=%h data=%h",
                         k, logAddr[logStart+k], logData[logStart+k], 5'(k), 32'(k));
            else passCount++;
        end
        checkCount++; if (readyViolations - violBase !== 0)
            $display("[TB] FAIL b2b_ready: got %0d cycles where rx_ready==imem_we, required 0", readyViolations - violBase);
        else passCount++;
        checkCount++; if (load_done !== 1'b1)
            $display("[TB] FAIL b2b_done: got %b, required 1", load_done);
        else passCount++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int logStart = logAddr.size();
        makeWords(2);
        csumXor = 8'h5A;
        sendFrame(8'd2, 1'b1);
        csumXor = 8'h00;
        settle();
        checkCount++; if (logAddr.size() - logStart !== 2)
            $display("[TB] FAIL csum_writes: got %0d writes, required 2", logAddr.size() - logStart);
        else passCount++;
        checkCount++; if ({core_reset, load_done, load_err} !== 3'b101)
            $display("[TB] FAIL csum_err: got core/done/err=%b%b%b, required 101", core_reset, load_done, load_err);
        else passCount++;
        makeWords(3);
        sendFrame(8'd3, 1'b1);
        settle();
        checkCount++; if ({core_reset, load_done, load_err, memDiffs() == 0} !== 4'b0101)
            $display("[TB] FAIL csum_recover: got core/done/err=%b%b%b bad=%0d, required 010 bad=0",
                     core_reset, load_done, load_err, memDiffs());
        else passCount++;
    endtask
`endif

    task automatic test_bad_length();
        logic [7:0] lens [2];
        int logStart = logAddr.size();
        lens[0] = 8'h00;
        lens[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            sendByte(HDR);
            sendByte(lens[i]);
            settle();
            checkCount++; if ({core_reset, load_done, load_err} !== 3'b101 || logAddr.size() != logStart)
                $display("[TB] FAIL badlen_%h: got core/done/err=%b%b%b writes=%0d, required 101 writes=0",
                         lens[i], core_reset, load_done, load_err, logAddr.size() - logStart);
            else passCount++;
        end
        makeWords(2);
        sendFrame(8'd2, 1'b1);
        settle();
        checkCount++; if ({load_done, load_err} !== 2'b10)
            $display("[TB] FAIL badlen_recover: got done/err=%b%b, required 10", load_done, load_err);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int logStart;
        int n = $urandom_range(1, 8);
        monitorEn = 1'b0;
        logStart = logAddr.size();
        sendByte(HDR); sendByte(8'h02); sendByte(8'h11); sendByte(8'h22);
        #2 reset = 1'b1;
        #1;
        checkCount++; if ({rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, load_err} !== {39'd0, 3'b100})
            $display("[TB] FAIL midreset_values: got ready=%b we=%b addr=%h wdata=%h core/done/err=%b%b%b, required all 0 except core_reset=1",
                     rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, load_err);
        else passCount++;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        monitorEn = 1'b1;
        checkCount++; if (logAddr.size() !== logStart)
            $display("[TB] FAIL midreset_nowrite: got %0d writes, required 0", logAddr.size() - logStart);
        else passCount++;
        makeWords(n);
        sendFrame(8'(n), 1'b1);
        settle();
        checkCount++; if (load_done !== 1'b1 || memDiffs() !== 0 || logAddr.size() - logStart !== n)
            $display("[TB] FAIL midreset_reload: got done=%b bad=%0d writes=%0d, required done=1 bad=0 writes=%0d",
                     load_done, memDiffs(), logAddr.size() - logStart, n);
        else passCount++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int logStart = logAddr.size();
            int n = $urandom_range(1, DEPTH);
            makeWords(n);
            sendFrame(8'(n), 1'b1);
            settle();
            checkCount++; if (logAddr.size() - logStart !== n || memDiffs() !== 0)
                $display("[TB] FAIL random_%0d: got writes=%0d bad=%0d, required writes=%0d bad=0",
                         it, logAddr.size() - logStart, memDiffs(), n);
            else passCount++;
            checkCount++; if ({core_reset, load_done, load_err} !== 3'b010)
                $display("[TB] FAIL random_%0d_status: got core/done/err=%b%b%b, required 010", it, core_reset, load_done, load_err);
            else passCount++;
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            refValid[k] = 1'b0;
            refMem[k]   = '0;
        end
        test_reset();
        test_garbage();
        test_single();
        test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_bad_length();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
